// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected classifier back-end.
// Contents: FSM state type, default class count, sign-magnitude conversion helper.
package fc_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned LOGIT_W_DEF     = 8;
  localparam int unsigned IDX_W           = 4;

  // Sign-magnitude to two's complement at the default logit width; -0 maps to 0.
  function automatic logic [LOGIT_W_DEF-1:0] sm_to_tc(input logic [LOGIT_W_DEF-1:0] x);
    logic [LOGIT_W_DEF-1:0] mag;
    mag = {1'b0, x[LOGIT_W_DEF-2:0]};
    return x[LOGIT_W_DEF-1] ? (LOGIT_W_DEF'(0) - mag) : mag;
  endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// Result port of fc_argmax: valid/ready handshake carrying the winning class.
// master: out_valid, class_idx, max_score, margin (out); out_ready (in).
// slave : mirror of master.
interface fc_argmax_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            class_idx;
  logic [DATA_WIDTH-1:0] max_score;
  logic [DATA_WIDTH:0]   margin;

  modport master (output out_valid, class_idx, max_score, margin, input out_ready);
  modport slave  (input out_valid, class_idx, max_score, margin, output out_ready);
endinterface

// File: rtl/fc_logit_norm.sv
// Combinational normalisation of one logit to two's complement.
// Ports: raw (in, DATA_WIDTH) logit as received; norm_c (out, DATA_WIDTH) two's complement value.
// SIGN_MAG=1 treats raw as {sign, magnitude}; SIGN_MAG=0 passes raw through.
module fc_logit_norm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGN_MAG   = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] norm_c
);

  logic [DATA_WIDTH-1:0] mag;

  // Negating a zero magnitude yields zero, so negative zero needs no special case.
  always_comb begin
    mag    = {1'b0, raw[DATA_WIDTH-2:0]};
    norm_c = raw;
    if (SIGN_MAG) begin
      norm_c = raw[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - mag) : mag;
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Classifier back-end: snapshots NUM_CLASSES logits on start, scans them one per cycle
// and reports winning index, its score and the top-1/top-2 margin.
// Ports: clk, rst (sync, active high), start (pulse), logits (packed bus, class k at
// [DATA_WIDTH*k +: DATA_WIDTH]), busy (SCAN/DONE), res (fc_argmax_if.master result port).
module fc_argmax
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter bit          SIGN_MAG    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
  output logic                              busy,
  fc_argmax_if.master                       res
);

  localparam int unsigned CNT_W = $clog2(NUM_CLASSES + 1);
  localparam int unsigned SEL_W = $clog2(NUM_CLASSES);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [DATA_WIDTH-1:0]        snap [NUM_CLASSES];
  logic [DATA_WIDTH-1:0]        cur_raw;
  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] best;
  logic signed [DATA_WIDTH-1:0] second;
  logic [IDX_W-1:0]             best_idx;
  logic [DATA_WIDTH:0]          diff_c;

  // Element under scan; only consumed while cnt < NUM_CLASSES.
  always_comb cur_raw = snap[cnt[SEL_W-1:0]];

  fc_logit_norm #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGN_MAG   (SIGN_MAG)
  ) u_norm (
    .raw    (cur_raw),
    .norm_c (cur)
  );

  // Sign-extended difference at DATA_WIDTH+1 bits cannot overflow.
  always_comb diff_c = {best[DATA_WIDTH-1], best} - {second[DATA_WIDTH-1], second};

  // Control FSM with best/second tracking; the extra SCAN step at cnt == NUM_CLASSES
  // registers the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      best          <= '0;
      second        <= '0;
      best_idx      <= '0;
      busy          <= 1'b0;
      res.out_valid <= 1'b0;
      res.class_idx <= '0;
      res.max_score <= '0;
      res.margin    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
              snap[k] <= logits[DATA_WIDTH*k +: DATA_WIDTH];
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == CNT_W'(NUM_CLASSES)) begin
            res.class_idx <= best_idx;
            res.max_score <= best;
            res.margin    <= diff_c;
            res.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            if (cnt == '0) begin
              best     <= cur;
              best_idx <= '0;
              second   <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else if (cur > best) begin
              second   <= best;
              best     <= cur;
              best_idx <= IDX_W'(cnt);
            end else if (cur > second) begin
              second <= cur;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (res.out_ready) begin
            res.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: one sign-magnitude and one two's complement instance.
module tb_fc_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_sm, start_tc;
  logic [79:0] logits_sm, logits_tc;
  logic        busy_sm, busy_tc;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat;

  fc_argmax_if #(.DATA_WIDTH(8)) if_sm ();
  fc_argmax_if #(.DATA_WIDTH(8)) if_tc ();

  fc_argmax #(.DATA_WIDTH(8), .NUM_CLASSES(10), .SIGN_MAG(1'b1)) dut_sm (
    .clk(clk), .rst(rst), .start(start_sm), .logits(logits_sm), .busy(busy_sm), .res(if_sm)
  );

  fc_argmax #(.DATA_WIDTH(8), .NUM_CLASSES(10), .SIGN_MAG(1'b0)) dut_tc (
    .clk(clk), .rst(rst), .start(start_tc), .logits(logits_tc), .busy(busy_tc), .res(if_tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] fill(input logic [7:0] v);
    logic [79:0] r;
    for (int k = 0; k < 10; k++) r[8*k +: 8] = v;
    return r;
  endfunction

  // Counts cycles from the start edge until out_valid, bounded at 40.
  task automatic wait_valid(input bit tc, output int n);
    n = 0;
    while (!(tc ? if_tc.out_valid : if_sm.out_valid) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_sm(input logic [79:0] v);
    logits_sm = v;
    start_sm  = 1'b1;
    tick();
    start_sm  = 1'b0;
  endtask

  task automatic check_sm(input string tag, input logic [3:0] idx,
                          input logic [7:0] score, input logic [8:0] mg);
    check({tag, "_idx"},    32'(if_sm.class_idx), 32'(idx));
    check({tag, "_score"},  32'(if_sm.max_score), 32'(score));
    check({tag, "_margin"}, 32'(if_sm.margin),    32'(mg));
  endtask

  task automatic handshake_sm(input string tag);
    if_sm.out_ready = 1'b1;
    tick();
    if_sm.out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 32'(if_sm.out_valid), 32'd0);
    check({tag, "_busy_after_hs"},  32'(busy_sm),         32'd0);
  endtask

  initial begin
    logic [79:0] v;
    rst = 1'b1;
    start_sm = 1'b0; start_tc = 1'b0;
    logits_sm = '0; logits_tc = '0;
    if_sm.out_ready = 1'b0; if_tc.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_busy",   32'(busy_sm),         32'd0);
    check("rst_valid",  32'(if_sm.out_valid), 32'd0);
    check_sm("rst", 4'd0, 8'h00, 9'h000);

    // Ascending 0..9
    for (int k = 0; k < 10; k++) v[8*k +: 8] = 8'(k);
    pulse_sm(v);
    check("asc_busy", 32'(busy_sm), 32'd1);
    wait_valid(1'b0, lat);
    check("asc_latency", 32'(lat), 32'd11);
    check_sm("asc", 4'd9, 8'h09, 9'd1);
    handshake_sm("asc");

    // Reset during SCAN clears the previous result
    v = fill(8'h85);
    v[8*3 +: 8] = 8'h81;
    pulse_sm(v);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("scanrst_busy",  32'(busy_sm),         32'd0);
    check("scanrst_valid", 32'(if_sm.out_valid), 32'd0);
    check_sm("scanrst", 4'd0, 8'h00, 9'h000);
    repeat (15) tick();
    check("scanrst_no_result", 32'(if_sm.out_valid), 32'd0);

    // Sign-magnitude negatives after reset
    pulse_sm(v);
    wait_valid(1'b0, lat);
    check("neg_latency", 32'(lat), 32'd11);
    check_sm("neg", 4'd3, 8'hFF, 9'd4);
    handshake_sm("neg");

    // Tie and negative zero
    v = fill(8'h00);
    v[8*2 +: 8] = 8'h40;
    v[8*7 +: 8] = 8'h40;
    v[8*0 +: 8] = 8'h80;
    pulse_sm(v);
    wait_valid(1'b0, lat);
    check_sm("tie", 4'd2, 8'h40, 9'd0);

    // Backpressure: start and new logits during DONE are ignored
    for (int c = 0; c < 20; c++) begin
      logits_sm = fill(8'h7F);
      start_sm  = (c % 5 == 2);
      tick();
    end
    start_sm = 1'b0;
    check("bp_valid_held", 32'(if_sm.out_valid), 32'd1);
    check("bp_busy_held",  32'(busy_sm),         32'd1);
    check_sm("bp", 4'd2, 8'h40, 9'd0);
    // Start coincident with the handshake is ignored too
    start_sm = 1'b1;
    handshake_sm("bp");
    start_sm = 1'b0;
    tick();
    check("bp_idle_busy", 32'(busy_sm), 32'd0);
    repeat (15) tick();
    check("bp_no_requeue", 32'(if_sm.out_valid), 32'd0);
    check_sm("bp_kept", 4'd2, 8'h40, 9'd0);

    // Start and reset together: reset wins
    rst = 1'b1;
    start_sm = 1'b1;
    logits_sm = fill(8'h01);
    tick();
    rst = 1'b0;
    start_sm = 1'b0;
    tick();
    check("rst_start_busy", 32'(busy_sm), 32'd0);

    // Two's complement extremes
    v = fill(8'h80);
    v[8*5 +: 8] = 8'h7F;
    logits_tc = v;
    start_tc = 1'b1;
    tick();
    start_tc = 1'b0;
    wait_valid(1'b1, lat);
    check("ext_latency", 32'(lat), 32'd11);
    check("ext_idx",    32'(if_tc.class_idx), 32'd5);
    check("ext_score",  32'(if_tc.max_score), 32'h7F);
    check("ext_margin", 32'(if_tc.margin),    32'h0FF);
    if_tc.out_ready = 1'b1;
    tick();
    check("ext_valid_after_hs", 32'(if_tc.out_valid), 32'd0);

    // All equal at the most negative value: class 0, zero margin
    logits_tc = fill(8'h80);
    start_tc = 1'b1;
    tick();
    start_tc = 1'b0;
    wait_valid(1'b1, lat);
    check("eq_latency", 32'(lat), 32'd11);
    check("eq_idx",    32'(if_tc.class_idx), 32'd0);
    check("eq_score",  32'(if_tc.max_score), 32'h80);
    check("eq_margin", 32'(if_tc.margin),    32'h000);
    // out_ready already high: result accepted on the next edge
    tick();
    check("eq_valid_after_hs", 32'(if_tc.out_valid), 32'd0);
    if_tc.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
